enc_8x3_stream: RTL
===================

ENC_8X3_STREAM -- requirements
Module: enc_8x3_stream

Interface
REQ-001 The block SHALL have no parameters; widths are fixed: 8-bit request vector, 3-bit index.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  request vector offered.
REQ-005 in_ready  output  1  block can accept a vector; high only in IDLE.
REQ-006 in_req  input  8  multi-hot request vector, bit i = line i.
REQ-007 out_valid  output  1  out_idx/out_last valid.
REQ-008 out_ready  input  1  consumer accepts current index.
REQ-009 out_idx  output  3  binary index of the granted request line.
REQ-010 out_last  output  1  high with the final index of the current vector.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The block SHALL implement states IDLE, ENC, OUT.
REQ-013 Input handshake at edge N (in_valid && in_ready) SHALL load pending <= in_req and go to ENC; in_req is ignored when no handshake occurs.
REQ-014 In ENC, if pending != 0, the next edge SHALL register out_idx = selected index, out_last = (pending has exactly one bit set), clear that bit in pending, and go to OUT; out_valid is therefore first high 2 edges after the input handshake.
REQ-015 In ENC with pending == 0, the block SHALL return to IDLE with no output beat (all-zero vector accepted and discarded).
REQ-016 In OUT, out_valid SHALL be 1 and out_idx/out_last SHALL hold stable until out_valid && out_ready.
REQ-017 Output handshake with out_last = 0 SHALL load the next index/out_last from pending on the same edge and stay in OUT (one index per cycle with out_ready held high).
REQ-018 Output handshake with out_last = 1 SHALL go to IDLE; in_ready rises the following cycle (no same-cycle accept).
REQ-019 Each set bit of an accepted vector SHALL be emitted exactly once; number of beats = popcount(in_req).
REQ-020 Default selection SHALL be fixed priority, highest set index first (7 down to 0).
REQ-021 out_valid SHALL be 0 in IDLE and ENC; in_ready SHALL be 0 in ENC and OUT.

Reset
REQ-022 Asserting rst_n low SHALL immediately force state IDLE, pending 0, out_valid 0, out_idx 0, out_last 0, busy 0, rr pointer 0; in_ready = 1 while reset is low.
REQ-023 Reset asserted mid-vector SHALL discard all remaining pending bits; no further beats are produced after release.
REQ-024 First input handshake SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro ENC_ROUND_ROBIN_EN SHALL select the priority scheme.
REQ-026 Without ENC_ROUND_ROBIN_EN: fixed priority per REQ-020; no pointer register exists.
REQ-027 With ENC_ROUND_ROBIN_EN: a 3-bit pointer holds the last emitted index; selection searches downward from pointer-1 with wrap 0->7; pointer updates on every output handshake and persists across vectors; after reset the first search starts at 7.

Verification
REQ-028 Reset release, in_req=8'b0010_0100 accepted -> out_valid 2 edges later, beats out_idx=5 (last=0), then 2 (last=1), then IDLE, in_ready=1.
REQ-029 in_req=8'hFF, out_ready held 1 -> 8 consecutive beats 7,6,...,0, out_last only on idx 0, busy high throughout.
REQ-030 in_req=8'h00 accepted -> no out_valid, busy high one cycle (ENC), back to IDLE.
REQ-031 in_req=8'h81, out_ready low 5 cycles -> out_idx=7 held stable with out_valid=1; release -> 7 then 0 with last.
REQ-032 rst_n pulled low during beat 2 of 8'hFF -> outputs zero immediately, no beats after release, next vector 8'h08 yields single beat idx=3, last=1.
REQ-033 With ENC_ROUND_ROBIN_EN: vector 8'h01 (emits 0), then 8'h81 -> order 7? no: search from 7 (0-1 wrap) -> 7 then 0; then vector 8'h11 after pointer=0 -> 4 then 0.

Source files
------------

// File: rtl/enc_8x3_stream_if.sv
// enc_8x3_stream_if: request-in / index-out stream handshake bundle
interface enc_8x3_stream_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_req;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       busy;
  modport master (
    output in_valid, in_req, out_ready,
    input  in_ready, out_valid, out_idx, out_last, busy
  );
  modport slave (
    input  in_valid, in_req, out_ready,
    output in_ready, out_valid, out_idx, out_last, busy
  );
endinterface

// File: rtl/enc_8x3_stream.sv
// enc_8x3_stream: streams the binary index of every set bit of an accepted 8-bit vector; ENC_ROUND_ROBIN_EN selects round-robin instead of fixed high-first priority
module enc_8x3_stream (
  input logic clk,
  input logic rst_n,
  enc_8x3_stream_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;
  state_t     state, state_nxt;
  logic [7:0] pending;
  logic [2:0] sel;
  logic       one;
  logic       in_hs, out_hs, load;
  assign in_hs  = bus.in_valid && bus.in_ready;
  assign out_hs = bus.out_valid && bus.out_ready;
  assign load   = (state == ENC && |pending) || (state == OUT && out_hs && !bus.out_last);
  assign one    = (pending & (pending - 8'd1)) == 8'd0;
`ifdef ENC_ROUND_ROBIN_EN
  logic [2:0] ptr, base, c;
  // search downward from the last emitted index (the beat leaving now, when in OUT), wrapping 0->7
  always_comb begin
    base = (state == OUT) ? bus.out_idx : ptr;
    sel  = '0;
    c    = '0;
    for (int k = 8; k >= 1; k--) begin
      c = base - 3'(k);
      if (pending[c]) sel = c;
    end
  end
  // pointer remembers the last emitted index across vectors
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (out_hs) ptr <= bus.out_idx;
`else
  // fixed priority: highest set index wins
  always_comb begin
    sel = '0;
    for (int i = 0; i < 8; i++) if (pending[i]) sel = 3'(i);
  end
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = in_hs ? ENC : IDLE;
      ENC:     state_nxt = |pending ? OUT : IDLE;
      OUT:     state_nxt = (out_hs && bus.out_last) ? IDLE : OUT;
      default: state_nxt = IDLE;
    endcase
  end
  // state-decoded handshake outputs
  always_comb begin
    bus.in_ready  = state == IDLE;
    bus.out_valid = state == OUT;
    bus.busy      = state != IDLE;
  end
  // capture vector, then peel off one index per beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending      <= '0;
      bus.out_idx  <= '0;
      bus.out_last <= 1'b0;
    end else if (in_hs) begin
      pending <= bus.in_req;
    end else if (load) begin
      pending      <= pending & ~(8'd1 << sel);
      bus.out_idx  <= sel;
      bus.out_last <= one;
    end
endmodule
